// File: rtl/regfile_wr_sched.sv
// -----------------------------------------------------------------------------
// regfile_wr_sched
//
// Write-port scheduler for the eight 8-bit CPU registers
// (B, C, D, E, H, L, A, F at indices 0..7).
//
// Three requesters share one registered write-data bus and a one-hot
// write-enable vector:
//   - ALU result    (8-bit, highest priority)
//   - memory load   (8-bit)
//   - IDU pair      (16-bit, issued as two consecutive 8-bit beats)
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   alu_*      ALU request: valid / idx / data, ready = grant this cycle
//   ld_*       load request: valid / idx / data, ready = grant this cycle
//   idu_*      pair request: valid / pair (0=BC,1=DE,2=HL,3=AF) / data,
//              ready = grant this cycle
//   reg_we     registered one-hot write enable, bit i = register i
//   reg_wd     registered write data shared by all registers
//   busy       high while the second pair beat is pending (state PAIR2)
//
// Parameters:
//   MASK_F         writes to F (index 7) force data[3:0] to zero
//   PAIR_HI_FIRST  pair writes issue the high register first when 1
// -----------------------------------------------------------------------------
module regfile_wr_sched #(
   parameter bit MASK_F        = 1'b1,
   parameter bit PAIR_HI_FIRST = 1'b1
) (
   input  logic        clk,
   input  logic        rst,

   input  logic        alu_valid,
   input  logic [2:0]  alu_idx,
   input  logic [7:0]  alu_data,
   output logic        alu_ready,

   input  logic        ld_valid,
   input  logic [2:0]  ld_idx,
   input  logic [7:0]  ld_data,
   output logic        ld_ready,

   input  logic        idu_valid,
   input  logic [1:0]  idu_pair,
   input  logic [15:0] idu_data,
   output logic        idu_ready,

   output logic [7:0]  reg_we,
   output logic [7:0]  reg_wd,
   output logic        busy
);

   typedef enum logic {
      IDLE  = 1'b0,
      PAIR2 = 1'b1
   } state_t;

   state_t      state_reg;
   logic [2:0]  pend_idx_reg;    // register index of the pending second beat
   logic [7:0]  pend_data_reg;   // data of the pending second beat
   logic [7:0]  reg_we_reg;
   logic [7:0]  reg_wd_reg;

   logic        idle;
   logic        alu_grant;
   logic        ld_grant;
   logic        idu_grant;

   logic [2:0]  hi_idx;
   logic [2:0]  lo_idx;
   logic [2:0]  first_idx;
   logic [7:0]  first_data;
   logic [2:0]  second_idx;
   logic [7:0]  second_data;

   logic        wr_valid;
   logic [2:0]  wr_idx;
   logic [7:0]  wr_data;
   logic [7:0]  wd_next;
   logic [7:0]  we_next;

   assign idle = (state_reg == IDLE);

   // Fixed priority ALU > LD > IDU, only while no pair beat is pending.
   assign alu_grant = idle && alu_valid;
   assign ld_grant  = idle && !alu_valid && ld_valid;
   assign idu_grant = idle && !alu_valid && !ld_valid && idu_valid;

   assign alu_ready = alu_grant;
   assign ld_ready  = ld_grant;
   assign idu_ready = idu_grant;

   // Pair p maps to high register 2p and low register 2p+1.
   assign hi_idx = {idu_pair, 1'b0};
   assign lo_idx = {idu_pair, 1'b1};

   always_comb begin
      if (PAIR_HI_FIRST) begin
         first_idx   = hi_idx;
         first_data  = idu_data[15:8];
         second_idx  = lo_idx;
         second_data = idu_data[7:0];
      end else begin
         first_idx   = lo_idx;
         first_data  = idu_data[7:0];
         second_idx  = hi_idx;
         second_data = idu_data[15:8];
      end
   end

   // Select the write that lands on the bus after the next edge. In PAIR2
   // no grant is possible, so the pending beat always wins there.
   always_comb begin
      wr_valid = 1'b0;
      wr_idx   = 3'd0;
      wr_data  = 8'h00;
      if (!idle) begin
         wr_valid = 1'b1;
         wr_idx   = pend_idx_reg;
         wr_data  = pend_data_reg;
      end else if (alu_grant) begin
         wr_valid = 1'b1;
         wr_idx   = alu_idx;
         wr_data  = alu_data;
      end else if (ld_grant) begin
         wr_valid = 1'b1;
         wr_idx   = ld_idx;
         wr_data  = ld_data;
      end else if (idu_grant) begin
         wr_valid = 1'b1;
         wr_idx   = first_idx;
         wr_data  = first_data;
      end
   end

   // The low nibble of F holds no flags, so it is always written as zero.
   always_comb begin
      wd_next = wr_data;
      if (MASK_F && (wr_idx == 3'd7)) begin
         wd_next[3:0] = 4'h0;
      end
   end

   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_we
         assign we_next[gi] = wr_valid && (wr_idx == 3'(gi));
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg     <= IDLE;
         pend_idx_reg  <= 3'd0;
         pend_data_reg <= 8'h00;
         reg_we_reg    <= 8'h00;
         reg_wd_reg    <= 8'h00;
      end else begin
         reg_we_reg <= we_next;
         // Data bus keeps its last value when nothing is written.
         if (wr_valid) begin
            reg_wd_reg <= wd_next;
         end
         case (state_reg)
            IDLE: begin
               if (idu_grant) begin
                  state_reg     <= PAIR2;
                  pend_idx_reg  <= second_idx;
                  pend_data_reg <= second_data;
               end
            end
            PAIR2: begin
               state_reg <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign reg_we = reg_we_reg;
   assign reg_wd = reg_wd_reg;
   assign busy   = (state_reg == PAIR2);

endmodule

// File: tb/tb_regfile_wr_sched.sv
module tb_regfile_wr_sched;

   logic        clk;
   logic        rst;
   logic        alu_valid;
   logic [2:0]  alu_idx;
   logic [7:0]  alu_data;
   logic        ld_valid;
   logic [2:0]  ld_idx;
   logic [7:0]  ld_data;
   logic        idu_valid;
   logic [1:0]  idu_pair;
   logic [15:0] idu_data;

   // Instance a: MASK_F=1, PAIR_HI_FIRST=1
   logic        alu_ready, ld_ready, idu_ready, busy;
   logic [7:0]  reg_we, reg_wd;
   // Instance b: MASK_F=0, PAIR_HI_FIRST=0
   logic        alu_ready_b, ld_ready_b, idu_ready_b, busy_b;
   logic [7:0]  reg_we_b, reg_wd_b;

   int n_cmp = 0;
   int n_bad = 0;

   regfile_wr_sched #(.MASK_F(1'b1), .PAIR_HI_FIRST(1'b1)) dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_idx(alu_idx), .alu_data(alu_data), .alu_ready(alu_ready),
      .ld_valid(ld_valid), .ld_idx(ld_idx), .ld_data(ld_data), .ld_ready(ld_ready),
      .idu_valid(idu_valid), .idu_pair(idu_pair), .idu_data(idu_data), .idu_ready(idu_ready),
      .reg_we(reg_we), .reg_wd(reg_wd), .busy(busy)
   );

   regfile_wr_sched #(.MASK_F(1'b0), .PAIR_HI_FIRST(1'b0)) dut_b (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_idx(alu_idx), .alu_data(alu_data), .alu_ready(alu_ready_b),
      .ld_valid(ld_valid), .ld_idx(ld_idx), .ld_data(ld_data), .ld_ready(ld_ready_b),
      .idu_valid(idu_valid), .idu_pair(idu_pair), .idu_data(idu_data), .idu_ready(idu_ready_b),
      .reg_we(reg_we_b), .reg_wd(reg_wd_b), .busy(busy_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end else begin
         $display("ok   %s: %h", tag, obs);
      end
   endtask

   task automatic wr_a(input string tag, input logic [7:0] we, input logic [7:0] wd);
      check({tag, " we"}, {8'h00, reg_we}, {8'h00, we});
      check({tag, " wd"}, {8'h00, reg_wd}, {8'h00, wd});
   endtask

   task automatic wr_b(input string tag, input logic [7:0] we, input logic [7:0] wd);
      check({tag, " we_b"}, {8'h00, reg_we_b}, {8'h00, we});
      check({tag, " wd_b"}, {8'h00, reg_wd_b}, {8'h00, wd});
   endtask

   task automatic rdy(input string tag, input logic a, input logic l, input logic i);
      check({tag, " rdy"}, {13'd0, alu_ready, ld_ready, idu_ready}, {13'd0, a, l, i});
   endtask

   task automatic clear_in();
      alu_valid = 1'b0; alu_idx = 3'd0; alu_data = 8'h00;
      ld_valid  = 1'b0; ld_idx  = 3'd0; ld_data  = 8'h00;
      idu_valid = 1'b0; idu_pair = 2'd0; idu_data = 16'h0000;
   endtask

   task automatic set_alu(input logic [2:0] i, input logic [7:0] d);
      alu_valid = 1'b1; alu_idx = i; alu_data = d;
   endtask

   task automatic set_ld(input logic [2:0] i, input logic [7:0] d);
      ld_valid = 1'b1; ld_idx = i; ld_data = d;
   endtask

   task automatic set_idu(input logic [1:0] p, input logic [15:0] d);
      idu_valid = 1'b1; idu_pair = p; idu_data = d;
   endtask

   // Inputs change just after the rising edge, outputs are checked on the falling edge.
   task automatic post();
      @(posedge clk);
      #1;
   endtask

   task automatic neg();
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b0;
      clear_in();
      post(); post();
      neg();
      wr_a("reset", 8'h00, 8'h00);
      check("reset busy", {15'd0, busy}, 16'd0);
      post();
      rst = 1'b1;

      // Single ALU write
      set_alu(3'd6, 8'h5A);
      neg(); rdy("alu single", 1'b1, 1'b0, 1'b0);
      post(); clear_in();
      neg(); wr_a("alu single", 8'h40, 8'h5A); wr_b("alu single", 8'h40, 8'h5A);
      post();
      neg(); wr_a("alu idle hold", 8'h00, 8'h5A);

      // Contention: ALU, LD, IDU all valid
      post();
      set_alu(3'd1, 8'h11); set_ld(3'd3, 8'h33); set_idu(2'd1, 16'hABCD);
      neg(); rdy("cont c0", 1'b1, 1'b0, 1'b0);
      post(); alu_valid = 1'b0;
      neg(); rdy("cont c1", 1'b0, 1'b1, 1'b0); wr_a("cont alu", 8'h02, 8'h11);
      post(); ld_valid = 1'b0;
      neg(); rdy("cont c2", 1'b0, 1'b0, 1'b1); wr_a("cont ld", 8'h08, 8'h33);
      post(); clear_in();
      neg(); wr_a("cont beat1", 8'h04, 8'hAB); wr_b("cont beat1", 8'h08, 8'hCD);
      check("cont busy", {15'd0, busy}, 16'd1);
      post();
      neg(); wr_a("cont beat2", 8'h08, 8'hCD); wr_b("cont beat2", 8'h04, 8'hAB);
      post();
      neg(); wr_a("cont done", 8'h00, 8'hCD);
      check("cont busy end", {15'd0, busy}, 16'd0);

      // Pair HL=BEEF with an ALU request arriving during beat 1
      post(); set_idu(2'd2, 16'hBEEF);
      neg(); rdy("hl accept", 1'b0, 1'b0, 1'b1);
      post(); clear_in(); set_alu(3'd0, 8'h77);
      neg(); rdy("hl pair2", 1'b0, 1'b0, 1'b0);
      check("hl busy", {15'd0, busy}, 16'd1);
      wr_a("hl beat1", 8'h10, 8'hBE); wr_b("hl beat1", 8'h20, 8'hEF);
      post();
      neg(); rdy("hl alu late", 1'b1, 1'b0, 1'b0);
      wr_a("hl beat2", 8'h20, 8'hEF); wr_b("hl beat2", 8'h10, 8'hBE);
      post(); clear_in();
      neg(); wr_a("hl alu", 8'h01, 8'h77); wr_b("hl alu", 8'h01, 8'h77);

      // Back-to-back pairs: BC=0102 then DE=0304, no bubble
      post(); set_idu(2'd0, 16'h0102);
      neg(); rdy("b2b p0", 1'b0, 1'b0, 1'b1);
      post(); set_idu(2'd1, 16'h0304);
      neg(); rdy("b2b pair2", 1'b0, 1'b0, 1'b0); wr_a("b2b b1", 8'h01, 8'h01);
      post();
      neg(); rdy("b2b p1", 1'b0, 1'b0, 1'b1); wr_a("b2b b2", 8'h02, 8'h02);
      post(); clear_in();
      neg(); wr_a("b2b b3", 8'h04, 8'h03);
      post();
      neg(); wr_a("b2b b4", 8'h08, 8'h04);

      // F masking via ALU, LD and pair AF
      post(); set_alu(3'd7, 8'hFF);
      neg();
      post(); clear_in();
      neg(); wr_a("fmask alu", 8'h80, 8'hF0); wr_b("fmask alu", 8'h80, 8'hFF);
      post(); set_ld(3'd7, 8'hAB);
      neg(); rdy("fmask ld", 1'b0, 1'b1, 1'b0);
      post(); clear_in();
      neg(); wr_a("fmask ld", 8'h80, 8'hA0); wr_b("fmask ld", 8'h80, 8'hAB);
      post(); set_idu(2'd3, 16'h12FF);
      neg();
      post(); clear_in();
      neg(); wr_a("fmask af b1", 8'h40, 8'h12); wr_b("fmask af b1", 8'h80, 8'hFF);
      post();
      neg(); wr_a("fmask af b2", 8'h80, 8'hF0); wr_b("fmask af b2", 8'h40, 8'h12);

      // Reset during PAIR2 aborts beat 2
      post(); set_idu(2'd0, 16'h1234);
      neg();
      post(); clear_in();
      neg(); wr_a("rstmid b1", 8'h01, 8'h12);
      check("rstmid busy", {15'd0, busy}, 16'd1);
      #1 rst = 1'b0;
      #1 wr_a("rstmid async", 8'h00, 8'h00);
      check("rstmid async busy", {15'd0, busy}, 16'd0);
      post(); rst = 1'b1;
      neg(); wr_a("rstmid no b2", 8'h00, 8'h00);
      check("rstmid busy post", {15'd0, busy}, 16'd0);
      post(); set_ld(3'd5, 8'h66); set_idu(2'd2, 16'h9999);
      neg(); rdy("rstmid idle", 1'b0, 1'b1, 1'b0);
      post(); clear_in();
      neg(); wr_a("rstmid ld", 8'h20, 8'h66);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
